// File: rtl/fsic_fpga_link.sv
// rtl/fsic_fpga_link.sv - FPGA-side FSIC serial link endpoint: AXIS beat <-> framed lane-words, AXI-lite CTRL
module fsic_fpga_link #(
    parameter int pADDR_WIDTH     = 15,
    parameter int pDATA_WIDTH     = 32,
    parameter int pSERIALIO_WIDTH = 12,
    parameter int pCLK_RATIO      = 4
) (
    input  logic                       axis_clk,
    input  logic                       axis_rst,
    input  logic                       axi_awvalid,
    input  logic [pADDR_WIDTH-1:0]     axi_awaddr,
    input  logic                       axi_wvalid,
    input  logic [pDATA_WIDTH-1:0]     axi_wdata,
    input  logic [3:0]                 axi_wstrb,
    output logic                       axi_awready,
    output logic                       axi_wready,
    input  logic                       axi_arvalid,
    input  logic [pADDR_WIDTH-1:0]     axi_araddr,
    input  logic                       axi_rready,
    output logic                       axi_arready,
    output logic                       axi_rvalid,
    output logic [pDATA_WIDTH-1:0]     axi_rdata,
    input  logic                       cc_is_enable,
    input  logic [31:0]                as_is_tdata,
    input  logic [3:0]                 as_is_tstrb,
    input  logic [3:0]                 as_is_tkeep,
    input  logic [1:0]                 as_is_tid,
    input  logic [1:0]                 as_is_tuser,
    input  logic                       as_is_tlast,
    input  logic                       as_is_tvalid,
    input  logic                       as_is_tready,
    output logic [31:0]                is_as_tdata,
    output logic [3:0]                 is_as_tstrb,
    output logic [3:0]                 is_as_tkeep,
    output logic [1:0]                 is_as_tid,
    output logic [1:0]                 is_as_tuser,
    output logic                       is_as_tlast,
    output logic                       is_as_tvalid,
    output logic                       is_as_tready,
    output logic [pSERIALIO_WIDTH-1:0] serial_txd,
    output logic                       serial_tclk,
    input  logic [pSERIALIO_WIDTH-1:0] serial_rxd,
    input  logic                       serial_rclk
);

    localparam int FW = pSERIALIO_WIDTH * pCLK_RATIO;
    localparam int PW = (pCLK_RATIO > 1) ? $clog2(pCLK_RATIO) : 1;
    localparam logic [PW-1:0] LAST = PW'(pCLK_RATIO - 1);

    logic [1:0] ctrl;
    logic       rxen;
    logic       txen;
    logic       rd_go;
    logic       wr_go;
    logic       remote_ready;

    assign rxen = ctrl[0];
    assign txen = ctrl[1];

    // A read in flight (accepted this cycle or awaiting rready) blocks writes.
    always_comb begin
        rd_go = !axis_rst && cc_is_enable && axi_arvalid && !axi_rvalid;
        wr_go = !axis_rst && cc_is_enable && axi_awvalid && axi_wvalid && !axi_rvalid && !rd_go;
    end

    assign axi_arready = rd_go;
    assign axi_awready = wr_go;
    assign axi_wready  = wr_go;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            ctrl       <= 2'b00;
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
        end else begin
            if (wr_go && axi_awaddr[pADDR_WIDTH-1:2] == '0 && axi_wstrb[0])
                ctrl <= axi_wdata[1:0];
            if (rd_go) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= (axi_araddr[pADDR_WIDTH-1:2] == '0) ?
                              {{(pDATA_WIDTH-2){1'b0}}, ctrl} : '0;
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0;
                axi_rdata  <= '0;
            end
        end
    end

    logic [PW-1:0]                                tx_phase;
    logic [pCLK_RATIO-1:0][pSERIALIO_WIDTH-1:0]   tx_words;
    logic [FW-1:0]                                new_frame;
    logic                                         tx_last;
    logic                                         tx_take;

    assign tx_last      = (tx_phase == LAST);
    assign is_as_tready = !axis_rst && txen && remote_ready && tx_last;
    assign tx_take      = as_is_tvalid && is_as_tready;

    // Idle frames still advertise local receive capacity in bit 46.
    always_comb begin
        new_frame = '0;
        if (tx_take) begin
            new_frame[31:0]  = as_is_tdata;
            new_frame[35:32] = as_is_tstrb;
            new_frame[39:36] = as_is_tkeep;
            new_frame[41:40] = as_is_tid;
            new_frame[43:42] = as_is_tuser;
            new_frame[44]    = as_is_tlast;
            new_frame[45]    = 1'b1;
        end
        new_frame[46] = as_is_tready;
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst || !txen) begin
            tx_phase    <= LAST;
            tx_words    <= '0;
            serial_txd  <= '0;
            serial_tclk <= 1'b0;
        end else if (tx_last) begin
            tx_words    <= new_frame;
            tx_phase    <= '0;
            serial_txd  <= new_frame[pSERIALIO_WIDTH-1:0];
            serial_tclk <= 1'b1;
        end else begin
            tx_phase    <= tx_phase + PW'(1);
            serial_txd  <= tx_words[tx_phase + PW'(1)];
            serial_tclk <= 1'b0;
        end
    end

    logic [PW-1:0]                                rx_phase;
    logic                                         rx_active;
    logic [pCLK_RATIO-1:0][pSERIALIO_WIDTH-1:0]   rx_words;
    logic [FW-1:0]                                rx_frame;

    // The final lane-word is taken straight from the pins when the frame completes.
    always_comb begin
        rx_frame = rx_words;
        rx_frame[FW-1 -: pSERIALIO_WIDTH] = serial_rxd;
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            rx_phase     <= '0;
            rx_active    <= 1'b0;
            rx_words     <= '0;
            remote_ready <= 1'b0;
            is_as_tdata  <= '0;
            is_as_tstrb  <= '0;
            is_as_tkeep  <= '0;
            is_as_tid    <= '0;
            is_as_tuser  <= '0;
            is_as_tlast  <= 1'b0;
            is_as_tvalid <= 1'b0;
        end else begin
            is_as_tvalid <= 1'b0;
            if (!rxen) begin
                rx_phase     <= '0;
                rx_active    <= 1'b0;
                remote_ready <= 1'b0;
            end else if (serial_rclk) begin
                rx_words[0] <= serial_rxd;
                rx_phase    <= PW'(1);
                rx_active   <= 1'b1;
            end else if (rx_active) begin
                if (rx_phase == LAST) begin
                    is_as_tdata  <= rx_frame[31:0];
                    is_as_tstrb  <= rx_frame[35:32];
                    is_as_tkeep  <= rx_frame[39:36];
                    is_as_tid    <= rx_frame[41:40];
                    is_as_tuser  <= rx_frame[43:42];
                    is_as_tlast  <= rx_frame[44];
                    is_as_tvalid <= rx_frame[45];
                    remote_ready <= rx_frame[46];
                    rx_active    <= 1'b0;
                end else begin
                    rx_words[rx_phase] <= serial_rxd;
                    rx_phase           <= rx_phase + PW'(1);
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{axi_awaddr[1:0], axi_araddr[1:0], axi_wdata[pDATA_WIDTH-1:2],
                           axi_wstrb[3:1], rx_words[pCLK_RATIO-1], rx_frame[FW-1:47]};

endmodule

// File: tb/tb_fsic_fpga_link.sv
// tb/tb_fsic_fpga_link.sv - randomized self-checking bench for fsic_fpga_link
module tb_fsic_fpga_link;

    localparam int S = 12;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tstrb;
        logic [3:0]  tkeep;
        logic [1:0]  tid;
        logic [1:0]  tuser;
        logic        tlast;
    } beat_t;

    typedef logic [3:0][S-1:0] frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        axi_awvalid, axi_wvalid, axi_awready, axi_wready;
    logic [14:0] axi_awaddr, axi_araddr;
    logic [31:0] axi_wdata, axi_rdata;
    logic [3:0]  axi_wstrb;
    logic        axi_arvalid, axi_rready, axi_arready, axi_rvalid;
    logic        cc_is_enable;
    logic [31:0] as_is_tdata, is_as_tdata;
    logic [3:0]  as_is_tstrb, as_is_tkeep, is_as_tstrb, is_as_tkeep;
    logic [1:0]  as_is_tid, as_is_tuser, is_as_tid, is_as_tuser;
    logic        as_is_tlast, as_is_tvalid, as_is_tready;
    logic        is_as_tlast, is_as_tvalid, is_as_tready;
    logic [S-1:0] serial_txd, serial_rxd, drv_rxd;
    logic        serial_tclk, serial_rclk, drv_rclk;
    logic        loop;

    assign serial_rxd  = loop ? serial_txd  : drv_rxd;
    assign serial_rclk = loop ? serial_tclk : drv_rclk;

    fsic_fpga_link dut (
        .axis_clk(clk), .axis_rst(rst),
        .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_wvalid(axi_wvalid),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_awready(axi_awready), .axi_wready(axi_wready),
        .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_rready(axi_rready),
        .axi_arready(axi_arready), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
        .cc_is_enable(cc_is_enable),
        .as_is_tdata(as_is_tdata), .as_is_tstrb(as_is_tstrb), .as_is_tkeep(as_is_tkeep),
        .as_is_tid(as_is_tid), .as_is_tuser(as_is_tuser), .as_is_tlast(as_is_tlast),
        .as_is_tvalid(as_is_tvalid), .as_is_tready(as_is_tready),
        .is_as_tdata(is_as_tdata), .is_as_tstrb(is_as_tstrb), .is_as_tkeep(is_as_tkeep),
        .is_as_tid(is_as_tid), .is_as_tuser(is_as_tuser), .is_as_tlast(is_as_tlast),
        .is_as_tvalid(is_as_tvalid), .is_as_tready(is_as_tready),
        .serial_txd(serial_txd), .serial_tclk(serial_tclk),
        .serial_rxd(serial_rxd), .serial_rclk(serial_rclk)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t make_frame(input beat_t b, input logic v, input logic r);
        return {1'b0, r, v, b.tlast, b.tuser, b.tid, b.tkeep, b.tstrb, b.tdata};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.tdata = $urandom();
        b.tstrb = 4'($urandom());
        b.tkeep = 4'($urandom());
        b.tid   = 2'($urandom());
        b.tuser = 2'($urandom());
        b.tlast = 1'($urandom());
        return b;
    endfunction

    function automatic beat_t rx_beat();
        beat_t b;
        b.tdata = is_as_tdata; b.tstrb = is_as_tstrb; b.tkeep = is_as_tkeep;
        b.tid = is_as_tid; b.tuser = is_as_tuser; b.tlast = is_as_tlast;
        return b;
    endfunction

    function automatic logic [127:0] all_outs();
        return {32'b0, axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata,
                is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tid, is_as_tuser, is_as_tlast,
                is_as_tvalid, is_as_tready, serial_txd, serial_tclk};
    endfunction

    task automatic set_beat(input beat_t b);
        as_is_tdata = b.tdata; as_is_tstrb = b.tstrb; as_is_tkeep = b.tkeep;
        as_is_tid = b.tid; as_is_tuser = b.tuser; as_is_tlast = b.tlast;
    endtask

    task automatic axi_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        #1;
        while (!(axi_awready && axi_wready) && n < 10) begin tick(); n++; end
        check("aw_handshake", 128'(n < 10), 128'(1));
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [14:0] a, output logic [31:0] d);
        int n = 0;
        axi_araddr = a; axi_arvalid = 1'b1;
        #1;
        while (!axi_arready && n < 10) begin tick(); n++; end
        check("ar_handshake", 128'(n < 10), 128'(1));
        tick();
        axi_arvalid = 1'b0;
        check("r_valid", 128'(axi_rvalid), 128'(1));
        d = axi_rdata;
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
    endtask

    task automatic send_words(input frame_t f, input int nw);
        for (int p = 0; p < nw; p++) begin
            drv_rclk = (p == 0);
            drv_rxd  = f[2'(p)];
            tick();
        end
        drv_rclk = 1'b0;
        drv_rxd  = '0;
    endtask

    task automatic wait_slot(input string tag);
        int n = 0;
        while (!is_as_tready && n < 40) begin tick(); n++; end
        check(tag, 128'(n < 40), 128'(1));
    endtask

    beat_t       q_beat[$];
    int          q_due[$];

    initial begin
        logic [31:0] d;
        beat_t       b, bb;
        frame_t      words, exp_f;
        int          n, cyc;
        logic        seen;

        rst = 1'b1; loop = 1'b0; cc_is_enable = 1'b1;
        axi_awvalid = 0; axi_wvalid = 0; axi_awaddr = '0; axi_wdata = '0; axi_wstrb = '0;
        axi_arvalid = 0; axi_araddr = '0; axi_rready = 0;
        set_beat('0); as_is_tvalid = 0; as_is_tready = 0;
        drv_rxd = '0; drv_rclk = 0;
        repeat (3) tick();
        check("reset_outputs", all_outs(), 128'(0));
        rst = 1'b0;
        tick();
        check("post_reset_outputs", all_outs(), 128'(0));

        // CTRL register access
        axi_write(15'h0, 32'h3, 4'h1);
        axi_read(15'h0, d);   check("ctrl_rd", 128'(d), 128'(3));
        axi_write(15'h4, 32'h3, 4'h1);
        axi_read(15'h4, d);   check("other_rd", 128'(d), 128'(0));
        axi_read(15'h0, d);   check("ctrl_kept", 128'(d), 128'(3));
        axi_write(15'h0, 32'h0, 4'hE);
        axi_read(15'h0, d);   check("ctrl_nostrb", 128'(d), 128'(3));
        axi_write(15'h0, 32'hFFFF_FFFC, 4'hF);
        axi_read(15'h0, d);   check("ctrl_clear", 128'(d), 128'(0));
        cc_is_enable = 1'b0;
        axi_arvalid = 1'b1; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        seen = 1'b0;
        repeat (4) begin #1; seen |= axi_arready | axi_awready | axi_wready; tick(); end
        check("disabled_no_ready", 128'(seen), 128'(0));
        axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        cc_is_enable = 1'b1;

        // TX only, remote not ready: idle frames, no send slot
        axi_write(15'h0, 32'h2, 4'h1);
        as_is_tready = 1'b1;
        set_beat(rand_beat()); as_is_tvalid = 1'b1;
        n = 0;
        while (!serial_tclk && n < 10) begin tick(); n++; end
        check("tclk_start", 128'(n < 10), 128'(1));
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 4; p++) begin
                words[2'(p)] = serial_txd;
                check("tclk_pulse", 128'(serial_tclk), 128'(p == 0));
                check("no_slot", 128'(is_as_tready), 128'(0));
                tick();
            end
            check("idle_frame", 128'(words), 128'(make_frame('0, 1'b0, 1'b1)));
        end
        as_is_tvalid = 1'b0;

        // Loopback, directed beat
        loop = 1'b1;
        axi_write(15'h0, 32'h3, 4'h1);
        b = '{tdata: 32'h5a5a5a5a, tstrb: 4'hF, tkeep: 4'hF, tid: 2'd1, tuser: 2'd1, tlast: 1'b1};
        set_beat(b); as_is_tvalid = 1'b1;
        wait_slot("slot_open");
        tick();
        as_is_tvalid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            words[2'(p)] = serial_txd;
            check("dir_tclk", 128'(serial_tclk), 128'(p == 0));
            if (p == 3) check("dir_early_tvalid", 128'(is_as_tvalid), 128'(0));
            if (p < 3) tick();
        end
        exp_f = make_frame(b, 1'b1, 1'b1);
        check("dir_word0", 128'(words[0]), 128'(12'ha5a));
        check("dir_word3_valid", 128'(words[3][9]), 128'(1));
        check("dir_word3_ready", 128'(words[3][10]), 128'(1));
        check("dir_frame", 128'(words), 128'(exp_f));
        tick();
        check("dir_tvalid", 128'(is_as_tvalid), 128'(1));
        check("dir_beat", 128'(rx_beat()), 128'(b));
        tick();
        check("dir_tvalid_1cyc", 128'(is_as_tvalid), 128'(0));
        check("dir_held", 128'(rx_beat()), 128'(b));

        // Loopback, randomized traffic with a remote-pause window
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            if (is_as_tvalid) begin
                if (q_beat.size() == 0) check("rx_unexpected", 128'(1), 128'(0));
                else begin
                    check("rx_beat", 128'(rx_beat()), 128'(q_beat[0]));
                    check("rx_latency", 128'(cyc), 128'(q_due[0]));
                    void'(q_beat.pop_front()); void'(q_due.pop_front());
                end
            end else if (q_due.size() != 0 && q_due[0] <= cyc) begin
                check("rx_missing", 128'(cyc), 128'(q_due[0]));
                void'(q_beat.pop_front()); void'(q_due.pop_front());
            end
            if (i == 139) check("paused_slot", 128'(is_as_tready), 128'(0));
            as_is_tready = !(i >= 100 && i < 140);
            b = rand_beat();
            set_beat(b);
            as_is_tvalid = (i < 260) ? 1'($urandom()) : 1'b0;
            #1;
            if (as_is_tvalid && is_as_tready) begin
                q_beat.push_back(b);
                q_due.push_back(cyc + 5);
            end
            tick();
            cyc++;
        end
        check("rx_drain", 128'(q_beat.size()), 128'(0));
        as_is_tvalid = 1'b0;
        as_is_tready = 1'b1;

        // Direct RX: frame-start strobe arriving mid-frame
        loop = 1'b0;
        axi_write(15'h0, 32'h1, 4'h1);
        bb = rand_beat();
        send_words(make_frame(rand_beat(), 1'b1, 1'b1), 2);
        check("partial_no_tvalid", 128'(is_as_tvalid), 128'(0));
        send_words(make_frame(bb, 1'b1, 1'b0), 4);
        check("restart_tvalid", 128'(is_as_tvalid), 128'(1));
        check("restart_beat", 128'(rx_beat()), 128'(bb));
        check("rx_only_no_slot", 128'(is_as_tready), 128'(0));
        tick();
        check("restart_1cyc", 128'(is_as_tvalid), 128'(0));
        bb = rand_beat();
        send_words(make_frame(rand_beat(), 1'b1, 1'b1), 3);
        check("late_partial_no_tvalid", 128'(is_as_tvalid), 128'(0));
        send_words(make_frame(bb, 1'b1, 1'b1), 4);
        check("late_restart_beat", 128'(rx_beat()), 128'(bb));
        check("late_restart_tvalid", 128'(is_as_tvalid), 128'(1));
        send_words(make_frame(rand_beat(), 1'b0, 1'b1), 4);
        check("idle_rx_no_tvalid", 128'(is_as_tvalid), 128'(0));
        axi_write(15'h0, 32'h0, 4'h1);
        send_words(make_frame(rand_beat(), 1'b1, 1'b1), 4);
        check("rxen_off_ignored", 128'(is_as_tvalid), 128'(0));

        // Reset in the middle of a looped-back frame
        loop = 1'b1;
        axi_write(15'h0, 32'h3, 4'h1);
        set_beat(rand_beat()); as_is_tvalid = 1'b1;
        wait_slot("rst_slot_open");
        tick();
        as_is_tvalid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midframe_reset_outputs", all_outs(), 128'(0));
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin tick(); seen |= is_as_tvalid; end
        check("reset_no_tvalid", 128'(seen), 128'(0));
        axi_read(15'h0, d);
        check("reset_ctrl", 128'(d), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
